bcd_serial_subtractor: RTL

Digit-serial multi-digit BCD subtractor. It is the inverse-operation companion to the team's combinational single-digit BCD adder. It computes |A − B| of two packed-BCD operands one decimal digit per clock, least-significant digit first, with a borrow chain. A negative intermediate result is re-complemented in a second serial pass through the same datapath, so a sign-magnitude result is produced. It sits behind the lab keypad/register front end and drives the BCD display path through a start/done handshake.

---
 rtl/bcd_serial_subtractor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A - B| for packed BCD, one digit per clock, LSD first.
// A borrow out of the top digit triggers a second pass (0 - working value) to recover the magnitude.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Y,
  output logic                  NEG,
  output logic                  ERR
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic [4*DIGITS-1:0] work;
  logic                borrow;
  logic                neg_work;
  logic                err_work;
  logic [IW-1:0]       idx;

  logic                in_err;
  logic [3:0]          op_a;
  logic [3:0]          op_b;
  logic                bin;
  logic [4:0]          diff;
  logic                bout;
  logic [3:0]          digit;
  logic                last;

  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (A[4*k +: 4] > 4'd9 || B[4*k +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // Digit 0 is processed straight from the inputs on the accepting edge,
  // so the remaining SUB steps run from the latched copies.
  always_comb begin
    op_a = 4'd0;
    op_b = 4'd0;
    bin  = 1'b0;
    case (state)
      IDLE: begin
        op_a = A[3:0];
        op_b = B[3:0];
      end
      SUB: begin
        op_a = a_reg[4*idx +: 4];
        op_b = b_reg[4*idx +: 4];
        bin  = borrow;
      end
      FIX: begin
        op_b = work[4*idx +: 4];
        bin  = borrow;
      end
      default: ;
    endcase
    diff  = {1'b0, op_a} - {1'b0, op_b} - {4'd0, bin};
    bout  = diff[4];
    digit = bout ? (diff[3:0] + 4'd10) : diff[3:0];
    last  = (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_err)    state_next = DONE;
          else if (last) state_next = bout ? FIX : DONE;
          else           state_next = SUB;
        end
      end
      SUB: if (last) state_next = bout ? FIX : DONE;
      FIX: if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      borrow   <= 1'b0;
      neg_work <= 1'b0;
      err_work <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
      Y        <= '0;
      NEG      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            err_work  <= in_err;
            work[3:0] <= digit;
            idx       <= last ? '0 : IW'(1);
            borrow    <= last ? 1'b0 : bout;
            neg_work  <= last & bout & ~in_err;
          end
        end
        SUB: begin
          work[4*idx +: 4] <= digit;
          if (last) begin
            idx      <= '0;
            borrow   <= 1'b0;
            neg_work <= bout;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= bout;
          end
        end
        // The final borrow of the complement pass carries no information.
        FIX: begin
          work[4*idx +: 4] <= digit;
          if (last) begin
            idx    <= '0;
            borrow <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= bout;
          end
        end
        DONE: begin
          Y   <= err_work ? '0 : work;
          NEG <= neg_work & ~err_work;
          ERR <= err_work;
        end
        default: ;
      endcase
    end
  end

endmodule
